// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and constants for the Ethernet receive frame checker.
//   - rx_state_e    : receive FSM states
//   - PREAMBLE_BYTE, SFD_BYTE : framing bytes
//   - CRC32_* constants and reflect32() bit-reversal helper
package eth_rx_pkg;

    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned CRC_WIDTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [BYTE_WIDTH-1:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [BYTE_WIDTH-1:0] SFD_BYTE      = 8'hD5;

    // Mirror a 32-bit word end for end (normal <-> reflected CRC form).
    function automatic logic [CRC_WIDTH-1:0] reflect32(input logic [CRC_WIDTH-1:0] x);
        logic [CRC_WIDTH-1:0] r;
        for (int i = 0; i < int'(CRC_WIDTH); i++) begin
            r[i] = x[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    localparam logic [CRC_WIDTH-1:0] CRC32_POLY      = 32'h04C11DB7;
    // Reflected polynomial, 0xEDB88320.
    localparam logic [CRC_WIDTH-1:0] CRC32_POLY_REFL = reflect32(CRC32_POLY);
    localparam logic [CRC_WIDTH-1:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Residue in normal bit order; the reflected register holds 0xDEBB20E3.
    localparam logic [CRC_WIDTH-1:0] CRC32_RESIDUE   = 32'hC704DD7B;

endpackage : eth_rx_pkg

// File: rtl/eth_rx_frame_checker_crc32_d8.sv
// crc32_d8: combinational one-byte CRC-32 step, LSB-first (reflected) form.
//   i_crc   : current CRC register
//   i_data  : byte to fold in, bit 0 first
//   o_crc_c : updated CRC register
module crc32_d8
    import eth_rx_pkg::*;
(
    input  logic [CRC_WIDTH-1:0]  i_crc,
    input  logic [BYTE_WIDTH-1:0] i_data,
    output logic [CRC_WIDTH-1:0]  o_crc_c
);

    logic [CRC_WIDTH-1:0] w_crc;

    // Eight unrolled right-shift steps with conditional polynomial XOR.
    always_comb begin
        w_crc = i_crc ^ {(CRC_WIDTH-BYTE_WIDTH)'(0), i_data};
        for (int i = 0; i < int'(BYTE_WIDTH); i++) begin
            if (w_crc[0]) begin
                w_crc = (w_crc >> 1) ^ CRC32_POLY_REFL;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
        o_crc_c = w_crc;
    end

endmodule : crc32_d8

// File: rtl/eth_rx_frame_checker.sv
// eth_rx_frame_checker: GMII receive front end. Strips preamble/SFD, runs CRC-32
// over the frame, forwards frame bytes with start-of-frame marking and emits a
// one-cycle status word after each completed frame.
//   iclk, i_rst             : clock, synchronous active-high reset
//   idv, irx_d, irx_er      : receive stream
//   odv, orx_d, osof        : forwarded bytes, osof on the first byte
//   ostatus_vld             : one-cycle end-of-frame pulse
//   ogood, ocrc_err, olen_err, olen : status, held until the next pulse
// Build option: RX_FCS_STRIP_EN withholds the 4 FCS bytes through a delay line.
module eth_rx_frame_checker
    import eth_rx_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = 8,
    parameter int unsigned pLEN_WIDTH  = 16,
    parameter int unsigned pMIN_FRAME  = 64,
    parameter int unsigned pMAX_FRAME  = 1536
) (
    input  logic                   iclk,
    input  logic                   i_rst,
    input  logic                   idv,
    input  logic [pDATA_WIDTH-1:0] irx_d,
    input  logic                   irx_er,
    output logic                   odv,
    output logic [pDATA_WIDTH-1:0] orx_d,
    output logic                   osof,
    output logic                   ostatus_vld,
    output logic                   ogood,
    output logic                   ocrc_err,
    output logic                   olen_err,
    output logic [pLEN_WIDTH-1:0]  olen
);

`ifdef RX_FCS_STRIP_EN
    localparam int unsigned LP_FCS_BYTES = 4;
    logic [LP_FCS_BYTES-1:0][pDATA_WIDTH-1:0] r_dly;
`endif

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic                   w_sfd;
    logic                   w_data_byte;
    logic                   w_frame_end;
    logic [CRC_WIDTH-1:0]   r_crc;
    logic [CRC_WIDTH-1:0]   w_crc_nxt;
    logic [pLEN_WIDTH-1:0]  r_cnt;
    logic [pLEN_WIDTH-1:0]  w_cnt_inc;
    logic                   r_err;
    logic                   w_crc_err;
    logic                   w_len_err;
    logic [pLEN_WIDTH-1:0]  w_olen;

    crc32_d8 u_crc32_d8 (
        .i_crc   (r_crc),
        .i_data  (irx_d),
        .o_crc_c (w_crc_nxt)
    );

    // State register.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_sfd       = 1'b0;
        w_data_byte = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (idv) begin
                    w_state_nxt = (irx_d == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!idv) begin
                    w_state_nxt = ST_IDLE;
                end else if (irx_d == PREAMBLE_BYTE) begin
                    w_state_nxt = ST_PREAMBLE;
                end else if (irx_d == SFD_BYTE) begin
                    w_state_nxt = ST_DATA;
                    w_sfd       = 1'b1;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (idv) begin
                    w_data_byte = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_frame_end = 1'b1;
                end
            end
            ST_DROP: begin
                if (!idv) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Saturating byte count; all-ones means "too many to count".
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + pLEN_WIDTH'(1);

    // Register is in reflected form, residue constant in normal form.
    assign w_crc_err = (reflect32(r_crc) != CRC32_RESIDUE);
    assign w_len_err = (r_cnt < pLEN_WIDTH'(pMIN_FRAME)) ||
                       (r_cnt > pLEN_WIDTH'(pMAX_FRAME)) || (&r_cnt);

`ifdef RX_FCS_STRIP_EN
    assign w_olen = (r_cnt >= pLEN_WIDTH'(LP_FCS_BYTES)) ?
                    r_cnt - pLEN_WIDTH'(LP_FCS_BYTES) : '0;
`else
    assign w_olen = r_cnt;
`endif

    // Frame accumulators: CRC, byte count, sticky receive error.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_crc <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_sfd) begin
            r_crc <= CRC32_INIT;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_data_byte) begin
            r_crc <= w_crc_nxt;
            r_cnt <= w_cnt_inc;
            if (irx_er) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef RX_FCS_STRIP_EN
    // Holds the last four bytes so the FCS never leaves the block.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            r_dly <= '0;
        end else if (w_data_byte) begin
            r_dly <= {r_dly[LP_FCS_BYTES-2:0], irx_d};
        end
    end
`endif

    // Registered byte forwarding and end-of-frame status.
    always_ff @(posedge iclk) begin
        if (i_rst) begin
            odv         <= 1'b0;
            orx_d       <= '0;
            osof        <= 1'b0;
            ostatus_vld <= 1'b0;
            ogood       <= 1'b0;
            ocrc_err    <= 1'b0;
            olen_err    <= 1'b0;
            olen        <= '0;
        end else begin
            odv         <= 1'b0;
            osof        <= 1'b0;
            ostatus_vld <= 1'b0;
            if (w_data_byte) begin
`ifdef RX_FCS_STRIP_EN
                // Byte n leaves when byte n+4 arrives.
                if (r_cnt >= pLEN_WIDTH'(LP_FCS_BYTES)) begin
                    odv   <= 1'b1;
                    orx_d <= r_dly[LP_FCS_BYTES-1];
                    osof  <= (r_cnt == pLEN_WIDTH'(LP_FCS_BYTES));
                end
`else
                odv   <= 1'b1;
                orx_d <= irx_d;
                osof  <= (r_cnt == '0);
`endif
            end
            if (w_frame_end) begin
                ostatus_vld <= 1'b1;
                ocrc_err    <= w_crc_err;
                olen_err    <= w_len_err;
                ogood       <= !w_crc_err && !w_len_err && !r_err;
                olen        <= w_olen;
            end
        end
    end

endmodule : eth_rx_frame_checker

// File: tb/tb_eth_rx_frame_checker.sv
// tb_eth_rx_frame_checker: directed bench for eth_rx_frame_checker. Builds frames
// with a locally computed FCS, drives them, and checks forwarded bytes and status.
`timescale 1ns/1ps
module tb_eth_rx_frame_checker;

`ifdef RX_FCS_STRIP_EN
    localparam int STRIP = 4;
`else
    localparam int STRIP = 0;
`endif

    logic        iclk = 1'b0;
    logic        i_rst;
    logic        idv;
    logic [7:0]  irx_d;
    logic        irx_er;
    logic        odv;
    logic [7:0]  orx_d;
    logic        osof;
    logic        ostatus_vld;
    logic        ogood;
    logic        ocrc_err;
    logic        olen_err;
    logic [15:0] olen;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       sof_q[$];
    logic       st_good_q[$];
    logic       st_crc_q[$];
    logic       st_lerr_q[$];
    int         st_len_q[$];
    int         order_bad = 0;
    int         sof_stray = 0;

    eth_rx_frame_checker dut (
        .iclk        (iclk),
        .i_rst       (i_rst),
        .idv         (idv),
        .irx_d       (irx_d),
        .irx_er      (irx_er),
        .odv         (odv),
        .orx_d       (orx_d),
        .osof        (osof),
        .ostatus_vld (ostatus_vld),
        .ogood       (ogood),
        .ocrc_err    (ocrc_err),
        .olen_err    (olen_err),
        .olen        (olen)
    );

    always #5 iclk = ~iclk;

    // Output monitor, sampled on the falling edge.
    always @(negedge iclk) begin
        if (odv) begin
            rx_q.push_back(orx_d);
            sof_q.push_back(osof);
        end
        if (osof && !odv) sof_stray++;
        if (ostatus_vld) begin
            st_good_q.push_back(ogood);
            st_crc_q.push_back(ocrc_err);
            st_lerr_q.push_back(olen_err);
            st_len_q.push_back(int'(olen));
            if (odv) order_bad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference CRC-32 step, bit at a time, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // frame_q <= payload 0,1,2.. of (total-4) bytes plus FCS.
    task automatic build_frame(input int total, input logic [7:0] fcs_xor);
        logic [31:0] c;
        frame_q.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < total - 4; i++) begin
            frame_q.push_back(8'(i));
            c = crc_step(c, 8'(i));
        end
        c = ~c;
        frame_q.push_back(c[7:0]);
        frame_q.push_back(c[15:8]);
        frame_q.push_back(c[23:16]);
        frame_q.push_back(c[31:24] ^ fcs_xor);
    endtask

    task automatic append_expected();
        for (int i = 0; i < frame_q.size() - STRIP; i++) exp_q.push_back(frame_q[i]);
    endtask

    task automatic clear_obs();
        rx_q.delete();
        sof_q.delete();
        exp_q.delete();
        st_good_q.delete();
        st_crc_q.delete();
        st_lerr_q.delete();
        st_len_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input logic er);
        idv    = 1'b1;
        irx_d  = d;
        irx_er = er;
        @(posedge iclk); #1;
    endtask

    task automatic idle(input int n);
        idv    = 1'b0;
        irx_d  = 8'h00;
        irx_er = 1'b0;
        repeat (n) begin @(posedge iclk); #1; end
    endtask

    // Preamble, SFD, frame_q, then exactly one idle cycle.
    task automatic send_frame(input int er_idx);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], i == er_idx);
        idle(1);
    endtask

    task automatic wait_status(input int n);
        for (int i = 0; i < 30 && st_good_q.size() < n; i++) begin
            @(posedge iclk); #1;
        end
    endtask

    task automatic check_status(input string tag, input logic good, input logic crc_e,
                                input logic len_e, input int total);
        int exp_len;
        exp_len = (total > STRIP) ? total - STRIP : 0;
        check({tag, "_pulse"}, 32'(st_good_q.size() > 0), 32'd1);
        if (st_good_q.size() > 0) begin
            check({tag, "_good"},    32'(st_good_q.pop_front()), 32'(good));
            check({tag, "_crc_err"}, 32'(st_crc_q.pop_front()),  32'(crc_e));
            check({tag, "_len_err"}, 32'(st_lerr_q.pop_front()), 32'(len_e));
            check({tag, "_olen"},    32'(st_len_q.pop_front()),  32'(exp_len));
        end
    endtask

    task automatic check_data(input string tag, input int n_frames, input int frame_len);
        int bad;
        int sofs;
        bad  = 0;
        sofs = 0;
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) bad++;
        end
        for (int i = 0; i < sof_q.size(); i++) begin
            if (sof_q[i]) begin
                sofs++;
                if (i % (frame_len - STRIP) != 0) bad++;
            end
        end
        check({tag, "_bytes"}, 32'(bad), 32'd0);
        check({tag, "_sofs"}, 32'(sofs), 32'(n_frames));
    endtask

    task automatic run_frame(input string tag, input int total, input logic [7:0] fcs_xor,
                             input int er_idx, input logic good, input logic crc_e,
                             input logic len_e);
        clear_obs();
        build_frame(total, fcs_xor);
        append_expected();
        send_frame(er_idx);
        wait_status(1);
        check_status(tag, good, crc_e, len_e, total);
        check_data(tag, 1, total);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst  = 1'b1;
        idv    = 1'b0;
        irx_d  = 8'h00;
        irx_er = 1'b0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        check("rst_odv", 32'(odv), 32'd0);
        check("rst_osof", 32'(osof), 32'd0);
        check("rst_status", {28'd0, ostatus_vld, ogood, ocrc_err, olen_err}, 32'd0);
        check("rst_olen", 32'(olen), 32'd0);
        @(posedge iclk); #1;
        i_rst = 1'b0;
        idle(3);

        run_frame("good64",   64,   8'h00, -1, 1'b1, 1'b0, 1'b0);
        run_frame("badfcs",   64,   8'h01, -1, 1'b0, 1'b1, 1'b0);
        run_frame("rxer",     64,   8'h00, 10, 1'b0, 1'b0, 1'b0);
        run_frame("short20",  20,   8'h00, -1, 1'b0, 1'b0, 1'b1);
        run_frame("long1540", 1540, 8'h00, -1, 1'b0, 1'b0, 1'b1);
        run_frame("max1536",  1536, 8'h00, -1, 1'b1, 1'b0, 1'b0);

        // No bytes between SFD and end of frame.
        clear_obs();
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        idle(1);
        wait_status(1);
        check_status("empty", 1'b0, 1'b1, 1'b1, 0);
        check("empty_nbytes", 32'(rx_q.size()), 32'd0);

        // Two frames with a single idle cycle between them.
        clear_obs();
        build_frame(64, 8'h00);
        append_expected();
        append_expected();
        send_frame(-1);
        send_frame(-1);
        wait_status(2);
        check("b2b_pulses", 32'(st_good_q.size()), 32'd2);
        check_status("b2b_a", 1'b1, 1'b0, 1'b0, 64);
        check_status("b2b_b", 1'b1, 1'b0, 1'b0, 64);
        check_data("b2b", 2, 64);

        // Reset asserted on data byte 30.
        clear_obs();
        build_frame(64, 8'h00);
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0);
        send_byte(8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) send_byte(frame_q[i], 1'b0);
        i_rst  = 1'b1;
        idv    = 1'b1;
        irx_d  = frame_q[30];
        @(posedge iclk); #1;
        i_rst  = 1'b0;
        idv    = 1'b0;
        @(negedge iclk);
        check("mrst_outs", {27'd0, odv, osof, ostatus_vld, ogood, ocrc_err}, 32'd0);
        check("mrst_len", {15'd0, olen_err, olen}, 32'd0);
        check("mrst_rxd", 32'(orx_d), 32'd0);
        idle(10);
        check("mrst_nostatus", 32'(st_good_q.size()), 32'd0);
        run_frame("after_rst", 64, 8'h00, -1, 1'b1, 1'b0, 1'b0);

        idle(5);
        check("order", 32'(order_bad), 32'd0);
        check("sof_stray", 32'(sof_stray), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_eth_rx_frame_checker

// File: doc/eth_rx_frame_checker.md
# eth_rx_frame_checker

Receive-side front end placed directly upstream of the packet-to-memory writer. Takes the raw 8-bit GMII-style receive stream, strips preamble/SFD, computes CRC-32 over the frame, and forwards frame bytes with start-of-frame marking. After each frame it emits a one-cycle status word (good/bad, length) that the writer uses to commit or roll back its write pointer.

## Interface
Parameters:
- pDATA_WIDTH, 8, byte bus width; only 8 is supported.
- pLEN_WIDTH, 16, width of the length counter and `olen`.
- pMIN_FRAME, 64, minimum legal frame length in bytes, including FCS.
- pMAX_FRAME, 1536, maximum legal frame length in bytes, including FCS.

Ports:
- iclk  in  1  single clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- idv  in  1  receive data valid.
- irx_d  in  8  receive byte.
- irx_er  in  1  receive error; sampled only while `idv`=1.
- odv  out  1  forwarded byte valid.
- orx_d  out  8  forwarded byte.
- osof  out  1  high with the first forwarded byte of a frame.
- ostatus_vld  out  1  one-cycle pulse; the frame has ended and status is valid.
- ogood  out  1  frame passed all checks; valid with `ostatus_vld`.
- ocrc_err  out  1  CRC residue mismatch; valid with `ostatus_vld`.
- olen_err  out  1  length outside [pMIN_FRAME, pMAX_FRAME]; valid with `ostatus_vld`.
- olen  out  pLEN_WIDTH  number of bytes forwarded on `orx_d` for this frame.

## Operation
State machine: IDLE, PREAMBLE, DATA, DROP.
- **IDLE**
  - `idv`=1 and `irx_d`=0x55 goes to PREAMBLE.
  - `idv`=1 with any other byte goes to DROP.
- **PREAMBLE**
  - `idv`=1 and 0x55 stays in PREAMBLE; any number of 0x55 bytes is accepted.
  - 0xD5 (SFD) goes to DATA. CRC is preset to 0xFFFFFFFF, the byte counter and error flag are cleared.
  - Any other byte goes to DROP.
  - `idv`=0 goes to IDLE with no status.
- **DATA**
  - Each byte with `idv`=1: CRC is updated, the byte counter is incremented (saturating at all-ones), and `irx_er`=1 sets the sticky error flag.
  - `idv`=0 ends the frame and goes to IDLE, scheduling the status pulse.
- **DROP**: waits for `idv`=0, then goes to IDLE. No forwarding, no status.
- **Status checks**
  - `ocrc_err`=1 when the final CRC register is not the residue 0xC704DD7B.
  - `olen_err`=1 when the total byte count (including FCS) is < pMIN_FRAME or > pMAX_FRAME.
  - `ogood` = !`ocrc_err` && !`olen_err` && !error flag.
- **Boundary cases**
  - Zero bytes after SFD: status with `olen`=0, `olen_err`=1, `ogood`=0.
  - A counter saturated at all-ones is reported as saturated and forces `olen_err`=1.
  - Back-to-back frames need only 1 idle cycle between them. The status pulse of frame N may coincide with PREAMBLE of frame N+1, and both must be handled.
  - `i_rst` mid-frame: all outputs 0, state IDLE, no status for the partial frame.
- **Reset values**: `odv`, `orx_d`, `osof`, `ostatus_vld`, `ogood`, `ocrc_err`, `olen_err`, `olen` are all 0.

## Timing
- All outputs are registered.
- Without strip: a byte sampled at cycle T appears on `odv`/`orx_d` at T+1.
- Last frame byte sampled at T, `idv`=0 sampled at T+1, `ostatus_vld` high at T+2. The status pulse is always strictly after the last `odv` of its frame.
- `osof` appears on the first DATA byte (the byte after SFD), coincident with its `odv`.
- `ostatus_vld` is high for exactly 1 cycle per completed frame. `ogood`, `ocrc_err`, `olen_err`, `olen` hold their value until the next status pulse.

## Configuration
- `RX_FCS_STRIP_EN` defined:
  - A 4-byte delay line withholds bytes. Byte n is forwarded when byte n+4 is sampled, so latency is 5 cycles from input.
  - The 4 FCS bytes are never forwarded.
  - `olen` = total count − 4, floored at 0.
  - Length checks still use the total count.
- `RX_FCS_STRIP_EN` undefined: every DATA byte is forwarded at 1-cycle latency, and `olen` = total count.

## Structure
- Package `eth_rx_pkg` holds:
  - the state enum;
  - PREAMBLE_BYTE 0x55, SFD_BYTE 0xD5;
  - CRC32_POLY 0x04C11DB7 (reflected form 0xEDB88320), CRC32_INIT 0xFFFFFFFF, CRC32_RESIDUE 0xC704DD7B.
- Sub-module `crc32_d8`: purely combinational, takes a 32-bit CRC and an 8-bit byte (LSB-first, reflected) and returns the next CRC. It is instantiated once.

## Test plan
- 7×0x55, 0xD5, then a 60-byte payload 0x00..0x3B with correct FCS (64 bytes total) -> one `ostatus_vld`, `ogood`=1, `olen`=64 (60 with strip), `osof` on byte 0x00.
- Same frame with the last FCS byte XORed by 0x01 -> `ocrc_err`=1, `ogood`=0, `olen_err`=0.
- 64-byte good frame with `irx_er`=1 on byte 10 -> `ogood`=0, `ocrc_err`=0, `olen_err`=0.
- 20-byte frame with valid FCS -> `olen_err`=1; 1540-byte frame -> `olen_err`=1; a good 1536-byte frame -> `ogood`=1.
- Two good 64-byte frames separated by 1 idle cycle -> two status pulses, both `ogood`=1, no byte lost or duplicated.
- `i_rst` pulsed at DATA byte 30 -> all outputs 0 the next cycle, no status, and the following good frame passes.
